// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEB_PRESS,
        HELD,
        DEB_RELEASE
    } state_t;

    localparam logic [3:0] COL_RESET = 4'b1110;

    // Row-major key legend: KEY_MAP[row][col]
    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Index of the lowest-numbered low (pressed) row.
    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Scan prescaler: tick_c is high for the last cycle of every DIV-cycle period.
module scan_tick_gen #(
    parameter int unsigned DIV = 48000
) (
    input  logic clk,
    input  logic reset,
    output logic tick_c
);

    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] LAST = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick_c = (count == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce and registered key events.
// Optional auto-repeat while held is enabled by defining KEY_REPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 48000,
    parameter int unsigned DEBOUNCE_TICKS = 20,
    parameter int unsigned REPEAT_TICKS   = 500
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic [3:0] rows_n,
    output logic [3:0] cols_n,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam int unsigned CNT_MAX = (DEBOUNCE_TICKS > REPEAT_TICKS) ? DEBOUNCE_TICKS : REPEAT_TICKS;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_TICKS - 1);
`endif

    logic             tick_c;
    logic [3:0]       rows_meta;
    logic [3:0]       rows_s;
    state_t           state,     state_next;
    logic [1:0]       col_idx,   col_next;
    logic [1:0]       row_idx,   row_next;
    logic [CNT_W-1:0] db_cnt,    db_next;
    logic [3:0]       cols_next;
    logic [3:0]       code_next;
    logic             held_next;
    logic             valid_next;
    logic             row_low_c;
`ifdef KEY_REPEAT_EN
    logic [CNT_W-1:0] rep_cnt,   rep_next;
`endif

    scan_tick_gen #(
        .DIV (SCAN_DIV)
    ) u_tick (
        .clk    (int_osc),
        .reset  (reset),
        .tick_c (tick_c)
    );

    // Two-flop synchronizer for the asynchronous row inputs.
    always_ff @(posedge int_osc) begin
        if (reset) begin
            rows_meta <= 4'hF;
            rows_s    <= 4'hF;
        end else begin
            rows_meta <= rows_n;
            rows_s    <= rows_meta;
        end
    end

    assign row_low_c = ~rows_s[row_idx];

    always_ff @(posedge int_osc) begin
        if (reset) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            db_cnt    <= '0;
            cols_n    <= COL_RESET;
            key_code  <= 4'h0;
            key_held  <= 1'b0;
            key_valid <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            state     <= state_next;
            col_idx   <= col_next;
            row_idx   <= row_next;
            db_cnt    <= db_next;
            cols_n    <= cols_next;
            key_code  <= code_next;
            key_held  <= held_next;
            key_valid <= valid_next;
`ifdef KEY_REPEAT_EN
            rep_cnt   <= rep_next;
`endif
        end
    end

    // Next-state and output logic; all decisions happen on tick cycles only.
    always_comb begin
        state_next = state;
        col_next   = col_idx;
        row_next   = row_idx;
        db_next    = db_cnt;
        cols_next  = cols_n;
        code_next  = key_code;
        held_next  = key_held;
        valid_next = 1'b0;
`ifdef KEY_REPEAT_EN
        rep_next   = rep_cnt;
`endif
        if (tick_c) begin
            case (state)
                SCAN: begin
                    if (rows_s == 4'hF) begin
                        col_next  = col_idx + 2'd1;
                        cols_next = ~(4'b0001 << col_next);
                    end else begin
                        row_next   = lowest_low(rows_s);
                        db_next    = '0;
                        state_next = DEB_PRESS;
                    end
                end
                DEB_PRESS: begin
                    if (!row_low_c) begin
                        state_next = SCAN;
                    end else if (db_cnt == DEB_LAST) begin
                        state_next = HELD;
                        code_next  = KEY_MAP[row_idx][col_idx];
                        held_next  = 1'b1;
                        valid_next = 1'b1;
`ifdef KEY_REPEAT_EN
                        rep_next   = '0;
`endif
                    end else begin
                        db_next = db_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!row_low_c) begin
                        db_next    = '0;
                        state_next = DEB_RELEASE;
                    end
`ifdef KEY_REPEAT_EN
                    else if (rep_cnt == REP_LAST) begin
                        valid_next = 1'b1;
                        rep_next   = '0;
                    end else begin
                        rep_next = rep_cnt + 1'b1;
                    end
`endif
                end
                DEB_RELEASE: begin
                    if (row_low_c) begin
                        db_next    = '0;
                        state_next = HELD;
                    end else if (db_cnt == DEB_LAST) begin
                        state_next = SCAN;
                        held_next  = 1'b0;
                        col_next   = col_idx + 2'd1;
                        cols_next  = ~(4'b0001 << col_next);
                    end else begin
                        db_next = db_cnt + 1'b1;
                    end
                end
                default: state_next = SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a behavioural 4x4 keypad matrix model.
// Define KEY_REPEAT_EN to exercise the auto-repeat build instead of the default one.
module tb_keypad_scanner;

    logic        int_osc = 1'b0;
    logic        reset;
    logic [3:0]  rows_n;
    logic [3:0]  cols_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;

    logic [15:0] pressed;
    logic [3:0]  exp_q [$];
    logic [3:0]  exp_code;
    logic        prev_valid = 1'b0;
    int          checks = 0;
    int          errors = 0;

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_TICKS (3),
        .REPEAT_TICKS   (2)
    ) dut (
        .int_osc   (int_osc),
        .reset     (reset),
        .rows_n    (rows_n),
        .cols_n    (cols_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held)
    );

    always #5 int_osc = ~int_osc;

    // Keypad matrix: pressed key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        rows_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !cols_n[c]) rows_n[r] = 1'b0;
            end
        end
    end

    // Every key_valid pulse is matched against the next expected key code.
    always @(negedge int_osc) begin
        if (key_valid === 1'b1) begin
            checks++;
            if (prev_valid === 1'b1) begin
                errors++;
                $display("FAIL event_width: key_valid high two cycles in a row, required one-cycle pulse");
            end
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: key_valid=1 key_code=%h, required no event", key_code);
            end else begin
                exp_code = exp_q.pop_front();
                if (key_code !== exp_code || key_held !== 1'b1) begin
                    errors++;
                    $display("FAIL event_code: key_code=%h key_held=%b, required key_code=%h key_held=1",
                             key_code, key_held, exp_code);
                end
            end
        end
        prev_valid = key_valid;
    end

    task automatic wait_held(input logic lvl, input int budget, output int n, output bit ok);
        n = 0;
        while (key_held !== lvl && n < budget) begin
            @(negedge int_osc);
            n++;
        end
        ok = (key_held === lvl);
    endtask

    task automatic test_reset();
        logic [3:0] exp_cols [4];
        int n;
        exp_cols = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        reset   = 1'b1;
        pressed = 16'h0;
        repeat (3) @(negedge int_osc);
        checks++;
        if (cols_n !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'h0 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: cols_n=%b key_valid=%b key_code=%h key_held=%b, required 1110 0 0 0",
                     cols_n, key_valid, key_code, key_held);
        end
        reset = 1'b0;
        for (int s = 0; s < 4; s++) begin
            logic [3:0] prev;
            prev = cols_n;
            n = 0;
            do begin
                @(negedge int_osc);
                n++;
            end while (cols_n === prev && n < 12);
            checks++;
            if (cols_n !== exp_cols[s] || n != 4) begin
                errors++;
                $display("FAIL scan_step%0d: cols_n=%b after %0d cycles, required %b after 4",
                         s, cols_n, n, exp_cols[s]);
            end
        end
    endtask

    task automatic test_single_key();
        int n;
        bit ok;
        pressed[6] = 1'b1;
        exp_q.push_back(4'h6);
        wait_held(1'b1, 300, n, ok);
        checks++;
        if (!ok || cols_n !== 4'b1011) begin
            errors++;
            $display("FAIL key6_press: key_held=%b cols_n=%b, required 1 and 1011", key_held, cols_n);
        end
        repeat (40) @(negedge int_osc);
        checks++;
        if (exp_q.size() != 0 || key_held !== 1'b1 || cols_n !== 4'b1011) begin
            errors++;
            $display("FAIL key6_hold: pending=%0d key_held=%b cols_n=%b, required 0 1 1011",
                     exp_q.size(), key_held, cols_n);
        end
        pressed[6] = 1'b0;
        wait_held(1'b0, 100, n, ok);
        checks++;
        if (!ok || n < 15 || n > 18) begin
            errors++;
            $display("FAIL key6_release_time: key_held=%b after %0d cycles, required 0 within 15..18", key_held, n);
        end
        checks++;
        if (cols_n !== 4'b0111) begin
            errors++;
            $display("FAIL key6_resume_col: cols_n=%b, required 0111", cols_n);
        end
    endtask

    task automatic test_bounce();
        int n;
        n = 0;
        while (cols_n !== 4'b1110 && n < 20) begin
            @(negedge int_osc);
            n++;
        end
        pressed[0] = 1'b1;
        repeat (4) @(negedge int_osc);
        checks++;
        if (cols_n !== 4'b1110 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL bounce_detect: cols_n=%b key_held=%b, required 1110 0", cols_n, key_held);
        end
        pressed[0] = 1'b0;
        n = 0;
        while (cols_n === 4'b1110 && n < 20) begin
            @(negedge int_osc);
            n++;
        end
        checks++;
        if (cols_n !== 4'b1101 || n != 8) begin
            errors++;
            $display("FAIL bounce_rescan: cols_n=%b after %0d cycles, required 1101 after 8", cols_n, n);
        end
        checks++;
        if (key_code !== 4'h6 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL bounce_code: key_code=%h key_held=%b, required 6 0", key_code, key_held);
        end
    endtask

    task automatic test_same_column();
        int n;
        bit ok;
        pressed[0] = 1'b1;
        pressed[8] = 1'b1;
        exp_q.push_back(4'h1);
        wait_held(1'b1, 200, n, ok);
        checks++;
        if (!ok || cols_n !== 4'b1110) begin
            errors++;
            $display("FAIL col0_press: key_held=%b cols_n=%b, required 1 1110", key_held, cols_n);
        end
        pressed[3] = 1'b1;
        repeat (40) @(negedge int_osc);
        checks++;
        if (exp_q.size() != 0 || key_held !== 1'b1 || cols_n !== 4'b1110 || key_code !== 4'h1) begin
            errors++;
            $display("FAIL other_col_ignored: pending=%0d key_held=%b cols_n=%b key_code=%h, required 0 1 1110 1",
                     exp_q.size(), key_held, cols_n, key_code);
        end
        exp_q.push_back(4'hA);
        pressed[0] = 1'b0;
        pressed[8] = 1'b0;
        wait_held(1'b0, 100, n, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL col0_release: key_held=%b, required 0", key_held);
        end
        wait_held(1'b1, 100, n, ok);
        checks++;
        if (!ok || cols_n !== 4'b0111 || key_code !== 4'hA) begin
            errors++;
            $display("FAIL col3_after_release: key_held=%b cols_n=%b key_code=%h, required 1 0111 A",
                     key_held, cols_n, key_code);
        end
        pressed[3] = 1'b0;
        wait_held(1'b0, 100, n, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL col3_release: key_held=%b, required 0", key_held);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit ok;
        pressed[5] = 1'b1;
        exp_q.push_back(4'h5);
        wait_held(1'b1, 200, n, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL key5_press: key_held=%b, required 1", key_held);
        end
        reset = 1'b1;
        @(negedge int_osc);
        checks++;
        if (cols_n !== 4'b1110 || key_held !== 1'b0 || key_valid !== 1'b0 || key_code !== 4'h0) begin
            errors++;
            $display("FAIL mid_reset: cols_n=%b key_held=%b key_valid=%b key_code=%h, required 1110 0 0 0",
                     cols_n, key_held, key_valid, key_code);
        end
        reset = 1'b0;
        exp_q.push_back(4'h5);
        wait_held(1'b1, 200, n, ok);
        checks++;
        if (!ok || key_code !== 4'h5 || cols_n !== 4'b1101) begin
            errors++;
            $display("FAIL key5_redetect: key_held=%b key_code=%h cols_n=%b, required 1 5 1101",
                     key_held, key_code, cols_n);
        end
        pressed[5] = 1'b0;
        wait_held(1'b0, 100, n, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL key5_release: key_held=%b, required 0", key_held);
        end
    endtask

    task automatic test_repeat();
        int n;
        bit ok;
        pressed[3] = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back(4'hA);
        wait_held(1'b1, 200, n, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL repeat_press: key_held=%b, required 1", key_held);
        end
        repeat (40) @(negedge int_osc);
        pressed[3] = 1'b0;
        wait_held(1'b0, 100, n, ok);
        checks++;
        if (!ok || key_code !== 4'hA) begin
            errors++;
            $display("FAIL repeat_release: key_held=%b key_code=%h, required 0 A", key_held, key_code);
        end
    endtask

    initial begin
        reset   = 1'b1;
        pressed = 16'h0;
        test_reset();
`ifdef KEY_REPEAT_EN
        test_repeat();
`else
        test_single_key();
        test_bounce();
        test_same_column();
        test_reset_mid();
`endif
        repeat (10) @(negedge int_osc);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: %0d expected events never seen, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
